// File: rtl/oldland_bus_arbiter.sv
// Round-robin arbiter sharing one word-addressed bus between fetch (read-only) and data masters,
// with a per-grant watchdog that returns an error when the slave never answers.
module oldland_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_BITS       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [3:0]  m_bytesel,
  output logic        m_wr_en,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error,
  output logic [1:0]  owner,
  output logic [7:0]  timeouts
);

  // State encoding doubles as the owner code, so owner comes straight from the flops.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TIMEOUT_CYCLES - 1);

  state_t              state;
  state_t              next_state;
  logic                last_d;
  logic [TMO_BITS-1:0] counter;
  logic                resp;
  logic                cur_req;
  logic                expire;

  assign resp    = m_ack | m_error;
  assign cur_req = (state == GNT_I) ? i_access :
                   (state == GNT_D) ? d_access : 1'b0;
  // A slave response in the final watchdog cycle wins over the timeout.
  assign expire  = (state != IDLE) && cur_req && !resp && (counter == TMO_LAST);

  assign owner  = state;
  assign i_data = m_data;
  assign d_data = m_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_access && d_access) begin
          next_state = last_d ? GNT_I : GNT_D;
        end else if (i_access) begin
          next_state = GNT_I;
        end else if (d_access) begin
          next_state = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        // Completion, watchdog expiry or the owner abandoning the request all end the grant.
        if (resp || expire || !cur_req) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_access  = 1'b0;
    m_addr    = 30'h0;
    m_bytesel = 4'h0;
    m_wr_en   = 1'b0;
    m_wr_val  = 32'h0;
    i_ack     = 1'b0;
    i_error   = 1'b0;
    d_ack     = 1'b0;
    d_error   = 1'b0;
    case (state)
      GNT_I: begin
        m_access  = i_access & ~expire;
        m_addr    = i_addr;
        m_bytesel = 4'b1111;
        i_ack     = m_ack;
        i_error   = m_error | expire;
      end
      GNT_D: begin
        m_access  = d_access & ~expire;
        m_addr    = d_addr;
        m_bytesel = d_bytesel;
        m_wr_en   = d_wr_en;
        m_wr_val  = d_wr_val;
        d_ack     = m_ack;
        d_error   = m_error | expire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d   <= 1'b1;
      counter  <= '0;
      timeouts <= 8'h00;
    end else begin
      if (state == IDLE && next_state != IDLE) begin
        last_d <= (next_state == GNT_D);
      end
      if (state == IDLE) begin
        counter <= '0;
      end else begin
        counter <= counter + TMO_BITS'(1);
      end
      if (expire && timeouts != 8'hff) begin
        timeouts <= timeouts + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// Randomised and directed bench for oldland_bus_arbiter against a transaction-level model.
module tb_oldland_bus_arbiter;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_access;
  logic [29:0] i_addr;
  logic [31:0] i_data;
  logic        i_ack;
  logic        i_error;
  logic        d_access;
  logic [29:0] d_addr;
  logic [3:0]  d_bytesel;
  logic        d_wr_en;
  logic [31:0] d_wr_val;
  logic [31:0] d_data;
  logic        d_ack;
  logic        d_error;
  logic        m_access;
  logic [29:0] m_addr;
  logic [3:0]  m_bytesel;
  logic        m_wr_en;
  logic [31:0] m_wr_val;
  logic [31:0] m_data;
  logic        m_ack;
  logic        m_error;
  logic [1:0]  owner;
  logic [7:0]  timeouts;

  int total = 0;
  int bad   = 0;

  oldland_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .TMO_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack), .i_error(i_error),
    .d_access(d_access), .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_en(d_wr_en),
    .d_wr_val(d_wr_val), .d_data(d_data), .d_ack(d_ack), .d_error(d_error),
    .m_access(m_access), .m_addr(m_addr), .m_bytesel(m_bytesel), .m_wr_en(m_wr_en),
    .m_wr_val(m_wr_val), .m_data(m_data), .m_ack(m_ack), .m_error(m_error),
    .owner(owner), .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Model: who holds the bus (0 none, 1 fetch, 2 data), cycles spent in the grant,
  // whether data was granted last, and the saturating expiry count.
  int          mg;
  int          ma;
  bit          ml_d;
  int          mt;
  logic        resp, req, x;
  logic [67:0] eb;
  logic [3:0]  er;

  always @(negedge clk) begin
    if (rst) begin
      mg = 0; ma = 0; ml_d = 1'b1; mt = 0;
    end else begin
      resp = m_ack | m_error;
      req  = (mg == 1) ? i_access : (mg == 2) ? d_access : 1'b0;
      x    = (mg != 0) && req && !resp && (ma == TMO - 1);
      eb   = '0;
      er   = '0;
      if (mg == 1) begin
        eb = {req && !x, i_addr, 4'hf, 1'b0, 32'h0};
        er = {m_ack, m_error | x, 2'b00};
      end
      if (mg == 2) begin
        eb = {req && !x, d_addr, d_bytesel, d_wr_en, d_wr_val};
        er = {2'b00, m_ack, m_error | x};
      end
      chk("bus", {m_access, m_addr, m_bytesel, m_wr_en, m_wr_val}, eb);
      chk("resp", {i_ack, i_error, d_ack, d_error}, er);
      chk("data", {i_data, d_data}, {m_data, m_data});
      chk("owner", owner, mg[1:0]);
      chk("timeouts", timeouts, mt[7:0]);
      if (mg == 0) begin
        ma = 0;
        if (i_access && (!d_access || ml_d)) begin
          mg = 1; ml_d = 1'b0;
        end else if (d_access) begin
          mg = 2; ml_d = 1'b1;
        end
      end else if (resp || x || !req) begin
        mg = 0;
        if (x && mt < 255) mt++;
      end else begin
        ma++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  int  cd;
  int  r;
  bit  i_done, d_done;

  initial begin
    rst = 1'b1;
    i_access = 0; i_addr = 0; d_access = 0; d_addr = 0; d_bytesel = 0;
    d_wr_en = 0; d_wr_val = 0; m_data = 0; m_ack = 0; m_error = 0;
    tick; tick;
    rst = 1'b0;
    smp;
    chk("rst_state", {m_access, owner, timeouts}, 11'h0);

    // Data write, slave answers in the fourth grant cycle.
    tick;
    d_access = 1; d_wr_en = 1; d_addr = 30'h100; d_bytesel = 4'b0011; d_wr_val = 32'hcafef00d;
    smp; chk("t1_req_idle", m_access, 1'b0);
    tick; smp;
    chk("t1_gnt", {m_access, owner, m_addr, m_bytesel, m_wr_en}, {1'b1, 2'b10, 30'h100, 4'b0011, 1'b1});
    tick; smp;
    tick; smp;
    tick; m_ack = 1; smp;
    chk("t1_ack", {d_ack, d_error, i_ack, owner}, {3'b100, 2'b10});
    tick; m_ack = 0; d_access = 0; d_wr_en = 0; smp;
    chk("t1_done", {owner, d_ack}, 3'b000);

    // Both request together: alternation starting with fetch.
    tick;
    i_access = 1; i_addr = 30'h2a; d_access = 1; d_addr = 30'h55; d_bytesel = 4'hf;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      smp;
      while (owner == 2'b00 && w < 6) begin
        tick; smp; w++;
      end
      chk("t2_order", owner, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick; m_ack = 1; m_data = (k == 0) ? 32'hdeadbeef : $urandom;
      smp;
      if (k == 0) chk("t4_fetch", {i_data, i_ack, d_ack}, {32'hdeadbeef, 1'b1, 1'b0});
      tick; m_ack = 0;
      if (k == 3) begin
        i_access = 0; d_access = 0;
      end
    end

    // Silent slave: watchdog fires in grant cycle 255.
    tick;
    d_access = 1; d_wr_en = 0; d_addr = 30'h3;
    for (int n = 0; n <= 255; n++) begin
      smp;
      if (n == 254) chk("t3_pre", d_error, 1'b0);
      if (n == 255) chk("t3_err", {d_error, d_ack, m_access}, 3'b100);
      if (n < 255) tick;
    end
    tick; d_access = 0; m_ack = 1; smp;
    chk("t3_late", {i_ack, d_ack, owner, timeouts}, {4'b0000, 8'd1});

    // Slave error on a write.
    tick; m_ack = 0; d_access = 1; d_wr_en = 1; d_addr = 30'h7; d_wr_val = 32'h1234;
    smp; tick; smp;
    tick; m_error = 1; smp;
    chk("t5_err", {d_error, d_ack}, 2'b10);
    tick; m_error = 0; d_access = 0; d_wr_en = 0; smp;
    chk("t5_idle", owner, 2'b00);

    // Reset in the middle of a data grant.
    tick; d_access = 1; smp;
    tick; smp; chk("t6_gnt", owner, 2'b10);
    @(posedge clk); #3; rst = 1; #1;
    chk("t6_rst", {m_access, owner, timeouts}, {1'b0, 2'b00, 8'd0});
    tick; rst = 0; smp;
    tick; smp; chk("t6_regnt", owner, 2'b10);
    tick; m_ack = 1; smp; chk("t6_post", d_ack, 1'b1);
    tick; m_ack = 0; d_access = 0;

    // Randomised traffic with a lazy, sometimes silent, sometimes chatty slave.
    cd = -1; i_done = 0; d_done = 0;
    for (int c = 0; c < 5000; c++) begin
      tick;
      m_ack = 0; m_error = 0; m_data = $urandom;
      if (cd == 0) begin
        r = int'($urandom % 8);
        m_error = (r < 2);
        m_ack = (r != 0);
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end else if (cd == -1 && $urandom % 25 == 0) begin
        m_ack = 1;
      end
      if (i_access && (i_done || $urandom % 80 == 0)) i_access = 0;
      else if (!i_access && $urandom % 3 == 0) begin
        i_access = 1; i_addr = 30'($urandom);
      end
      if (d_access && (d_done || $urandom % 80 == 0)) d_access = 0;
      else if (!d_access && $urandom % 3 == 0) begin
        d_access = 1; d_addr = 30'($urandom); d_bytesel = 4'($urandom);
        d_wr_en = 1'($urandom); d_wr_val = $urandom;
      end
      smp;
      i_done = i_ack | i_error;
      d_done = d_ack | d_error;
      if (!m_access) cd = -1;
      else if (cd == -1) cd = ($urandom % 50 == 0) ? -2 : int'($urandom % 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
